// File: rtl/calc_regfile.sv
// Register bank for the integer calculator: NREGS signed registers with sticky overflow
// flags, wrapping cursor, second read port, clear-all. Optional undo via CALC_REGFILE_UNDO_EN.
module calc_regfile #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREGS = 4,
    localparam int unsigned IDXW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    left,
    input  logic                    right,
    input  logic                    down,
    input  logic [1:0]              mode,
    input  logic                    load,
    input  logic signed [WIDTH-1:0] new_value,
    input  logic                    overflow,
    input  logic                    clear_all,
    input  logic                    undo,
    input  logic [IDXW-1:0]         rd_idx,
    output logic [IDXW-1:0]         cur_idx,
    output logic signed [WIDTH-1:0] cur_value,
    output logic                    cur_ovf,
    output logic signed [WIDTH-1:0] rd_value,
    output logic                    rd_ovf,
    output logic                    ovf_any,
    output logic                    undo_valid
);

    localparam logic [1:0]      MODE_SEL = 2'd2;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NREGS - 1);

    logic signed [WIDTH-1:0] r_regs [NREGS];
    logic [NREGS-1:0]        r_flags;
    logic [IDXW-1:0]         r_cur;

    logic                    w_sel;
    logic [IDXW-1:0]         w_cur_nxt;
    logic                    w_do_clear;
    logic                    w_do_load;
    logic                    w_do_ovf;
    logic                    w_wr_en;
    logic signed [WIDTH-1:0] w_wr_val;
    logic                    w_wr_flag;
    logic                    w_rd_ok;

    // Cursor movement and single-write arbitration; writes use the pre-move cursor
    always_comb begin
        w_sel      = (mode == MODE_SEL);
        w_cur_nxt  = r_cur;
        w_do_clear = 1'b0;
        w_do_load  = 1'b0;
        w_do_ovf   = 1'b0;
        w_wr_val   = r_regs[r_cur];
        w_wr_flag  = r_flags[r_cur];

        if (w_sel && left && !right) begin
            w_cur_nxt = (r_cur == '0) ? IDX_LAST : r_cur - IDXW'(1);
        end else if (w_sel && right && !left) begin
            w_cur_nxt = (r_cur == IDX_LAST) ? '0 : r_cur + IDXW'(1);
        end

        if (!clear_all) begin
            if (w_sel && down) begin
                w_do_clear = 1'b1;
            end else if (load) begin
                w_do_load = 1'b1;
            end else if (overflow) begin
                w_do_ovf = 1'b1;
            end
        end

        if (w_do_clear) begin
            w_wr_val  = '0;
            w_wr_flag = 1'b0;
        end else if (w_do_load) begin
            w_wr_val  = new_value;
            w_wr_flag = r_flags[r_cur] | overflow;
        end else if (w_do_ovf) begin
            w_wr_flag = 1'b1;
        end

        w_wr_en = w_do_clear | w_do_load | w_do_ovf;
    end

`ifdef CALC_REGFILE_UNDO_EN
    logic                    r_undo_valid;
    logic [IDXW-1:0]         r_undo_idx;
    logic signed [WIDTH-1:0] r_undo_val;
    logic                    r_undo_flag;
    logic                    w_undo_fire;

    assign w_undo_fire = undo && r_undo_valid && !clear_all && !w_wr_en;

    // Single-entry history: snapshot of the register about to be overwritten
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_undo_valid <= 1'b0;
            r_undo_idx   <= '0;
            r_undo_val   <= '0;
            r_undo_flag  <= 1'b0;
        end else if (clear_all) begin
            r_undo_valid <= 1'b0;
        end else if (w_wr_en) begin
            r_undo_valid <= 1'b1;
            r_undo_idx   <= r_cur;
            r_undo_val   <= r_regs[r_cur];
            r_undo_flag  <= r_flags[r_cur];
        end else if (w_undo_fire) begin
            r_undo_valid <= 1'b0;
        end
    end

    assign undo_valid = r_undo_valid;
`else
    logic w_unused_undo;

    assign w_unused_undo = undo;
    assign undo_valid    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur <= '0;
        end else begin
            r_cur <= w_cur_nxt;
        end
    end

    // Register array and flags: clear_all, then the arbitrated write, then undo restore
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_flags <= '0;
        end else if (clear_all) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_flags <= '0;
        end else if (w_wr_en) begin
            r_regs[r_cur]  <= w_wr_val;
            r_flags[r_cur] <= w_wr_flag;
        end
`ifdef CALC_REGFILE_UNDO_EN
        else if (w_undo_fire) begin
            r_regs[r_undo_idx]  <= r_undo_val;
            r_flags[r_undo_idx] <= r_undo_flag;
        end
`endif
    end

    // Combinational read ports; out-of-range operand index reads as zero
    assign w_rd_ok = ({1'b0, rd_idx} < (IDXW + 1)'(NREGS));

    always_comb begin
        cur_idx   = r_cur;
        cur_value = r_regs[r_cur];
        cur_ovf   = r_flags[r_cur];
        rd_value  = '0;
        rd_ovf    = 1'b0;
        if (w_rd_ok) begin
            rd_value = r_regs[rd_idx];
            rd_ovf   = r_flags[rd_idx];
        end
        ovf_any = |r_flags;
    end

endmodule

// File: doc/calc_regfile.md
# calc_regfile

Parametrised register bank for the integer calculator: NREGS signed registers of WIDTH bits, each with a sticky overflow flag. A cursor selects the active register and wraps in both directions. The bank adds a second independent read port for operand fetch, a clear-all command and an optional one-level undo. It sits between the button/mode front end and the ALU, replacing the fixed four-register, 16-bit bank.

## Interface
Parameters:
- WIDTH, 16, data width in bits (signed two's complement), ≥ 2
- NREGS, 4, number of registers, ≥ 2; IDXW = $clog2(NREGS) is a localparam

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- left  in  1  single-cycle pulse, move cursor down one (debounced upstream)
- right  in  1  single-cycle pulse, move cursor up one
- down  in  1  single-cycle pulse, clear selected register (select mode only)
- mode  in  2  calculator mode; 2'd2 = register-select mode
- load  in  1  write new_value into selected register
- new_value  in  WIDTH  signed write data
- overflow  in  1  ALU overflow for the value being loaded; sets sticky flag of selected register
- clear_all  in  1  zero every register and flag
- undo  in  1  revert last write (UNDO build only)
- rd_idx  in  IDXW  operand read-port index
- cur_idx  out  IDXW  cursor position
- cur_value  out  WIDTH  contents of register cur_idx
- cur_ovf  out  1  sticky flag of register cur_idx
- rd_value  out  WIDTH  contents of register rd_idx
- rd_ovf  out  1  sticky flag of register rd_idx
- ovf_any  out  1  OR of all sticky flags
- undo_valid  out  1  an undo is available

## Operation
- Reset: cursor 0, all registers 0, all flags 0, undo_valid 0; every output 0.
- Cursor moves only when mode==2'd2. left: 0 wraps to NREGS-1, else idx-1. right: NREGS-1 wraps to 0, else idx+1. left and right in the same cycle: no move. rd_idx ≥ NREGS (non-power-of-2 NREGS): rd_value=0, rd_ovf=0.
- Write priority per cycle, highest first: clear_all > clear (mode==2'd2 && down) > load. Only one write occurs per cycle.
  - clear_all: every register and every flag to 0.
  - clear: selected register and its flag to 0; overflow is ignored that cycle.
  - load: selected register gets new_value. The flag is set to 1 if overflow is high, otherwise it keeps its value (sticky).
- overflow without load: sets the flag of the selected register; the value is unchanged.
- Every write targets the cursor value from before any move in the same cycle.
- Reads are combinational from the register array; there is no read-side state.

## Timing
- Write latency 1: a value written at edge N is visible on cur_value/rd_value after edge N. There is no write-to-read bypass in the same cycle.
- Cursor update is visible on cur_idx after the edge. cur_value follows combinationally.
- ovf_any is combinational OR of the flags.
- rst_n assertion mid-operation clears all state immediately, independent of clk. Deassertion is synchronised upstream.

## Configuration
- CALC_REGFILE_UNDO_EN defined:
  - Each write (load, clear, or overflow-only flag set) saves the prior value, flag and index of the target register into a single-entry undo buffer and sets undo_valid.
  - undo with undo_valid=1 restores that register and clears undo_valid.
  - undo is lowest priority: it is ignored if any write occurs the same cycle.
  - clear_all and reset empty the buffer (undo_valid=0).
- Not defined: undo is ignored, undo_valid is tied 0, and no buffer storage is synthesised.

## Test plan
- Wrap: reset, mode=2; 1 left pulse -> cur_idx=3 (NREGS=4); then 1 right pulse -> cur_idx=0; left+right together -> cur_idx unchanged. With mode=0, right -> no move.
- Load and sticky overflow: cursor=1, load new_value=-5 -> after one edge cur_value=16'hFFFB, cur_ovf=0. Then load 7 with overflow=1 -> cur_ovf=1, ovf_any=1. Then load 3 with overflow=0 -> cur_ovf stays 1.
- Clear priority: load=1, new_value=9, down=1, mode=2, overflow=1 same cycle -> register 0, flag 0. Then clear_all while load is asserted -> all registers and flags 0.
- Read port: registers {10,20,30,40}; sweep rd_idx 0..3 -> rd_value 10,20,30,40, independent of cur_idx=2.
- Async reset: assert rst_n=0 mid-cycle after loading 0x7FFF -> all outputs 0 before the next clk edge.
- Undo (macro on): r2=5, load 8 -> undo_valid=1; undo -> r2=5, undo_valid=0. A second undo -> no change. With macro off, the same stimulus leaves r2=8 and undo_valid=0.
